// File: rtl/mem_wb_pipe_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe_reg
//   Elastic pipeline stage for the MEM->WB boundary (usable at any stage
//   boundary). Carries a memory read word, an ALU result word and a register
//   write address through a valid/ready handshake backed by a two-entry skid
//   buffer. The upstream ready is a register output, so there is never a
//   combinational path from out_ready to in_ready.
//
//   Also provides a synchronous flush, a write-back enable and a saturating
//   stall counter.
//
// Parameters
//   DATA_W  width of the rData / Result fields
//   ADDR_W  width of the write-address field
//   CNT_W   width of stall_cnt
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   flush      discard every held entry this cycle, plus any offered input
//   in_valid   upstream has an entry
//   in_ready   stage can take an entry (registered, = !skid valid)
//   rData_i    memory read data
//   Result_i   ALU result
//   wAddr_i    destination register
//   out_valid  main entry present
//   out_ready  downstream consumes the main entry
//   rData      main entry read data
//   Result     main entry result
//   wAddr      main entry destination register
//   wb_en      out_valid && (wAddr != 0)
//   stall_cnt  cycles with out_valid && !out_ready (saturating, no wrap)
// -----------------------------------------------------------------------------
module mem_wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rData_i,
  input  logic [DATA_W-1:0] Result_i,
  input  logic [ADDR_W-1:0] wAddr_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] rData,
  output logic [DATA_W-1:0] Result,
  output logic [ADDR_W-1:0] wAddr,
  output logic              wb_en,
  output logic [CNT_W-1:0]  stall_cnt
);

  // One pipeline entry; packing keeps main/skid moves to a single assignment.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] waddr;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             m_v_q,    m_v_d;     // main entry valid
  logic             s_v_q,    s_v_d;     // skid entry valid
  entry_t           m_data_q, m_data_d;  // main entry payload (drives outputs)
  entry_t           s_data_q, s_data_d;  // skid entry payload (internal)
  logic [CNT_W-1:0] cnt_q,    cnt_d;     // stall counter

  entry_t in_entry;
  logic   accept;
  logic   fire;

  assign in_entry = '{rdata: rData_i, result: Result_i, waddr: wAddr_i};

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // in_ready comes straight from the skid flag: the stage can always take one
  // more entry unless the skid slot is already occupied.
  assign in_ready  = !s_v_q;
  assign out_valid = m_v_q;
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    m_v_d    = m_v_q;
    s_v_d    = s_v_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    cnt_d    = cnt_q;

    if (flush) begin
      // Flush wins over accept and fire. The stall counter is deliberately
      // left alone so stall statistics survive pipeline kills.
      m_v_d    = 1'b0;
      s_v_d    = 1'b0;
      m_data_d = '0;
      s_data_d = '0;
    end else begin
      if (!m_v_q) begin
        // Empty stage: skid is empty too (s_v implies m_v).
        if (accept) begin
          m_v_d    = 1'b1;
          m_data_d = in_entry;
        end
      end else if (!s_v_q) begin
        if (fire) begin
          // Main drains this cycle; refill it directly or go empty. The
          // payload registers hold their last value when going empty.
          if (accept) begin
            m_data_d = in_entry;
          end else begin
            m_v_d = 1'b0;
          end
        end else if (accept) begin
          // Main is blocked; park the new entry in the skid slot.
          s_v_d    = 1'b1;
          s_data_d = in_entry;
        end
      end else begin
        // Both full: no accept is possible. On fire, promote skid to main.
        if (fire) begin
          m_data_d = s_data_q;
          s_v_d    = 1'b0;
        end
      end

      // Stall counter saturates at all-ones instead of wrapping.
      if (m_v_q && !out_ready && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the payload registers are reset as well as the valid flags,
      // because the outputs are architecturally visible and must read zero
      // after reset; resetting only the flags would be enough for protocol
      // correctness but not for that.
      m_v_q    <= 1'b0;
      s_v_q    <= 1'b0;
      m_data_q <= '0;
      s_data_q <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      m_v_q    <= m_v_d;
      s_v_q    <= s_v_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rData     = m_data_q.rdata;
  assign Result    = m_data_q.result;
  assign wAddr     = m_data_q.waddr;
  assign stall_cnt = cnt_q;

  // Writes to register 0 are architecturally discarded.
  assign wb_en = m_v_q && (m_data_q.waddr != '0);

  // ---------------------------------------------------------------------------
  // Invariant: the skid slot is only ever used behind a full main slot.
  // ---------------------------------------------------------------------------
  a_skid_implies_main : assert property (
    @(posedge clk) disable iff (!rst) s_v_q |-> m_v_q
  );

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
module tb_mem_wb_pipe_reg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;   // small so saturation is reachable quickly

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] addr;
  } pay_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rData_i;
  logic [DATA_W-1:0] Result_i;
  logic [ADDR_W-1:0] wAddr_i;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] rData;
  logic [DATA_W-1:0] Result;
  logic [ADDR_W-1:0] wAddr;
  logic              wb_en;
  logic [CNT_W-1:0]  stall_cnt;

  mem_wb_pipe_reg #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rData_i  (rData_i),
    .Result_i (Result_i),
    .wAddr_i  (wAddr_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rData    (rData),
    .Result   (Result),
    .wAddr    (wAddr),
    .wb_en    (wb_en),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of at most two entries, the value the
  // output registers last showed, and a saturating stall count.
  pay_t q[$];
  pay_t hold;
  int   cnt;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam int OBS_W = 3 + ADDR_W + 2 * DATA_W + CNT_W;

  wire [OBS_W-1:0] obs = {out_valid, in_ready, wb_en, wAddr, rData, Result, stall_cnt};

  function automatic logic [OBS_W-1:0] exp_obs();
    pay_t p;
    logic ov, ir, wb;
    logic [CNT_W-1:0] c;
    ov = (q.size() > 0);
    ir = (q.size() < 2);
    p  = ov ? q[0] : hold;
    wb = ov && (p.addr != 0);
    c  = CNT_W'(cnt);
    return {ov, ir, wb, p.addr, p.rdata, p.result, c};
  endfunction

  function automatic pay_t rnd_pay();
    pay_t p;
    p.rdata  = $urandom;
    p.result = $urandom;
    p.addr   = ADDR_W'($urandom_range(0, 31));
    return p;
  endfunction

  // Drive one cycle of inputs, advance one edge, update the model to match.
  task automatic step(input logic r, input logic fl, input logic iv,
                      input logic ordy, input pay_t p);
    int sz;
    rst       = r;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    rData_i   = p.rdata;
    Result_i  = p.result;
    wAddr_i   = p.addr;
    @(posedge clk);
    sz = q.size();
    if (!r) begin
      q.delete();
      hold = '0;
      cnt  = 0;
    end else if (fl) begin
      q.delete();
      hold = '0;
    end else begin
      if (sz > 0 && !ordy && cnt < (2 ** CNT_W) - 1) cnt++;
      if (sz > 0 && ordy) void'(q.pop_front());
      if (iv && sz < 2) q.push_back(p);
      if (q.size() > 0) hold = q[0];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    pay_t p;
    for (int i = 0; i < 2; i++) begin
      p = rnd_pay();
      step(1'b0, 1'b0, 1'b1, 1'b0, p);
      n_checks++;
      if (obs !== exp_obs()) begin
        n_fail++;
        $display("FAIL reset[%0d] got=%h want=%h", i, obs, exp_obs());
      end
    end
    // Explicit reset values.
    n_checks++;
    if ({out_valid, in_ready, rData, Result, wAddr, stall_cnt} !==
        {1'b0, 1'b1, {DATA_W{1'b0}}, {DATA_W{1'b0}}, {ADDR_W{1'b0}}, {CNT_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_values got ov=%b ir=%b rd=%h res=%h wa=%0d sc=%0d want 0 1 0 0 0 0",
               out_valid, in_ready, rData, Result, wAddr, stall_cnt);
    end
  endtask

  task automatic test_streaming();
    pay_t a, b;
    a = '{rdata: 32'd1, result: 32'd2, addr: 5'd3};
    b = '{rdata: 32'd4, result: 32'd5, addr: 5'd6};
    step(1'b1, 1'b0, 1'b1, 1'b1, a);
    n_checks++;
    if ({out_valid, in_ready, wb_en, rData, Result, wAddr} !== {3'b111, 32'd1, 32'd2, 5'd3}) begin
      n_fail++;
      $display("FAIL stream_a got ov=%b ir=%b wb=%b rd=%0d res=%0d wa=%0d want 1 1 1 1 2 3",
               out_valid, in_ready, wb_en, rData, Result, wAddr);
    end
    step(1'b1, 1'b0, 1'b1, 1'b1, b);
    n_checks++;
    if ({out_valid, in_ready, wb_en, rData, Result, wAddr} !== {3'b111, 32'd4, 32'd5, 5'd6}) begin
      n_fail++;
      $display("FAIL stream_b got ov=%b ir=%b wb=%b rd=%0d res=%0d wa=%0d want 1 1 1 4 5 6",
               out_valid, in_ready, wb_en, rData, Result, wAddr);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, rnd_pay());
    n_checks++;
    if (obs !== exp_obs()) begin
      n_fail++;
      $display("FAIL stream_drain got=%h want=%h", obs, exp_obs());
    end
  endtask

  task automatic test_skid();
    pay_t a, b, c;
    a = rnd_pay(); a.addr = 5'd7;
    b = rnd_pay(); b.addr = 5'd8;
    c = rnd_pay(); c.addr = 5'd10;
    step(1'b1, 1'b0, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 1'b1, 1'b0, b);
    n_checks++;
    if (in_ready !== 1'b0 || wAddr !== 5'd7) begin
      n_fail++;
      $display("FAIL skid_full got ir=%b wa=%0d want ir=0 wa=7", in_ready, wAddr);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, c);
      n_checks++;
      if (obs !== exp_obs()) begin
        n_fail++;
        $display("FAIL skid_hold[%0d] got=%h want=%h", i, obs, exp_obs());
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, (i < 2), 1'b1, c);
      n_checks++;
      if (obs !== exp_obs()) begin
        n_fail++;
        $display("FAIL skid_drain[%0d] got=%h want=%h", i, obs, exp_obs());
      end
    end
  endtask

  task automatic test_flush();
    pay_t nine;
    int   sc_before;
    step(1'b1, 1'b0, 1'b1, 1'b0, rnd_pay());
    step(1'b1, 1'b0, 1'b1, 1'b0, rnd_pay());
    sc_before = cnt;
    nine = rnd_pay(); nine.addr = 5'd9;
    step(1'b1, 1'b1, 1'b1, 1'b0, nine);
    n_checks++;
    if ({out_valid, in_ready, rData, Result, wAddr} !== {2'b01, {(2 * DATA_W + ADDR_W){1'b0}}} ||
        stall_cnt !== CNT_W'(sc_before)) begin
      n_fail++;
      $display("FAIL flush got ov=%b ir=%b rd=%h res=%h wa=%0d sc=%0d want 0 1 0 0 0 %0d",
               out_valid, in_ready, rData, Result, wAddr, stall_cnt, sc_before);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, rnd_pay());
      n_checks++;
      if (obs !== exp_obs() || (out_valid && wAddr == 5'd9)) begin
        n_fail++;
        $display("FAIL flush_after[%0d] got=%h want=%h", i, obs, exp_obs());
      end
    end
  endtask

  task automatic test_zero_reg();
    pay_t z;
    z = '{rdata: 32'h1234_5678, result: 32'hDEAD_BEEF, addr: 5'd0};
    step(1'b1, 1'b0, 1'b1, 1'b1, z);
    n_checks++;
    if ({out_valid, wb_en, Result} !== {2'b10, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL zero_reg got ov=%b wb=%b res=%h want 1 0 deadbeef", out_valid, wb_en, Result);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, z);
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 1'b1, 1'b0, rnd_pay());
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, rnd_pay());
      n_checks++;
      if (obs !== exp_obs()) begin
        n_fail++;
        $display("FAIL sat[%0d] got=%h want=%h", i, obs, exp_obs());
      end
    end
    n_checks++;
    if (stall_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_value got=%0d want=15", stall_cnt);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, rnd_pay());
    n_checks++;
    if ({stall_cnt, out_valid, in_ready} !== {4'd0, 2'b01}) begin
      n_fail++;
      $display("FAIL sat_reset got sc=%0d ov=%b ir=%b want 0 0 1", stall_cnt, out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 29) == 0),
           $urandom_range(0, 1), ($urandom_range(0, 2) != 0), rnd_pay());
      n_checks++;
      if (obs !== exp_obs()) begin
        n_fail++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs, exp_obs());
      end
    end
  endtask

  initial begin
    hold      = '0;
    cnt       = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rData_i   = '0;
    Result_i  = '0;
    wAddr_i   = '0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_zero_reg();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
